// File: rtl/simple_cpu_pkg.sv
// Shared constants and types for the simple_cpu core.
// Opcode/func encodings, FSM states, instruction field positions.
package simple_cpu_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  localparam logic FUNC_ADD = 1'b0;
  localparam logic FUNC_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2
  } state_e;

  localparam int OP_HI    = 19;
  localparam int OP_LO    = 18;
  localparam int X1_HI    = 17;
  localparam int X1_LO    = 16;
  localparam int X2_HI    = 15;
  localparam int X2_LO    = 14;
  localparam int X3_HI    = 13;
  localparam int X3_LO    = 12;
  localparam int OFF_HI   = 11;
  localparam int OFF_LO   = 4;
  localparam int FUNC_BIT = 0;

endpackage

// File: rtl/simple_cpu_cu.sv
// Control unit: FETCH/EXEC/WB sequencer, IR, ALU and register file.
// Drives the data memory read/write ports owned by the top level.
module simple_cpu_cu
  import simple_cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic [ADDR_BITS-1:0]   mem_raddr,
  output logic [ADDR_BITS-1:0]   mem_waddr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  output logic                   mem_we
);

  state_e state_q, state_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0]  alu_q, alu_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [DATA_WIDTH-1:0]  st_q, st_d;
  logic [DATA_WIDTH-1:0]  regfile   [4];
  logic [DATA_WIDTH-1:0]  regfile_d [4];

  logic [1:0]            op;
  logic [1:0]            x1, x2, x3;
  logic                  func;
  logic [DATA_WIDTH-1:0] off;
  logic [DATA_WIDTH-1:0] opa, opb;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] ea_full;
  logic                  unused_bits;

  assign op   = ir_q[OP_HI:OP_LO];
  assign x1   = ir_q[X1_HI:X1_LO];
  assign x2   = ir_q[X2_HI:X2_LO];
  assign x3   = ir_q[X3_HI:X3_LO];
  assign func = ir_q[FUNC_BIT];
  assign off  = DATA_WIDTH'(ir_q[OFF_HI:OFF_LO]);

  assign opa = regfile[x2];
  assign opb = regfile[x3];

  assign alu_res = (func == FUNC_SUB) ? opa - opb
                                      : opa + opb;
  assign ea_full = opa + off;

  // Address wraps modulo the memory depth by truncation.
  assign mem_raddr = ea_full[ADDR_BITS-1:0];
  assign mem_waddr = alu_q[ADDR_BITS-1:0];
  assign mem_wdata = st_q;

  assign unused_bits = ^{ir_q[OFF_LO-1:FUNC_BIT+1],
                         ea_full[DATA_WIDTH-1:ADDR_BITS]};

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    alu_d     = alu_q;
    data_d    = data_q;
    st_d      = st_q;
    regfile_d = regfile;
    mem_we    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d   = (op == OP_ALU) ? alu_res : ea_full;
        data_d  = mem_rdata;
        st_d    = regfile[x1];
        state_d = S_WB;
      end
      S_WB: begin
        unique case (op)
          OP_ALU:   regfile_d[x1] = alu_q;
          OP_LOAD:  regfile_d[x1] = data_q;
          OP_STORE: mem_we = 1'b1;
          default:  ;
        endcase
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      alu_q   <= '0;
      data_q  <= '0;
      st_q    <= '0;
      for (int i = 0; i < 4; i++)
        regfile[i] <= DATA_WIDTH'(i);
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      alu_q   <= alu_d;
      data_q  <= data_d;
      st_q    <= st_d;
      regfile <= regfile_d;
    end
  end

endmodule

// File: rtl/simple_cpu.sv
// Minimal multi-cycle CPU: one instruction every three clocks.
// Owns the data memory; sequencing and registers live in CU1.
module simple_cpu
  import simple_cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20
) (
  input logic                   clk,
  input logic                   rst,
  input logic [INSTR_WIDTH-1:0] instruction
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_WIDTH-1:0] data_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];

  logic [ADDR_BITS-1:0]  mem_raddr;
  logic [ADDR_BITS-1:0]  mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;

  simple_cpu_cu #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) CU1 (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction),
    .mem_rdata  (mem_rdata),
    .mem_raddr  (mem_raddr),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we)
  );

  // Read is combinational here; CU1 latches it at the EXEC edge.
  assign mem_rdata = data_mem[mem_raddr];

  always_comb begin
    data_mem_d = data_mem;
    if (mem_we)
      data_mem_d[mem_waddr] = mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        data_mem[i] <= '0;
    end else begin
      data_mem <= data_mem_d;
    end
  end

endmodule

// File: tb/tb_simple_cpu.sv
// Self-checking bench for simple_cpu with a reference model.
// Directed program from the datasheet plus random instruction runs.
module tb_simple_cpu;
  import simple_cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic [19:0] instruction;

  int n_tests;
  int n_fail;

  logic [7:0] m_rf  [4];
  logic [7:0] m_mem [32];

  simple_cpu dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'(i);
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
  endfunction

  function automatic void model_exec(input logic [19:0] ins);
    int op, a1, a2, a3, off, ad, sum;
    op  = int'(ins[19:18]);
    a1  = int'(ins[17:16]);
    a2  = int'(ins[15:14]);
    a3  = int'(ins[13:12]);
    off = int'(ins[11:4]);
    ad  = (int'(m_rf[a2]) + off) % 32;
    if (op == 1) begin
      if (ins[0])
        sum = int'(m_rf[a2]) - int'(m_rf[a3]) + 256;
      else
        sum = int'(m_rf[a2]) + int'(m_rf[a3]);
      m_rf[a1] = 8'(sum % 256);
    end else if (op == 2) begin
      m_rf[a1] = m_mem[ad];
    end else if (op == 3) begin
      m_mem[ad] = m_rf[a1];
    end
  endfunction

  function automatic logic [31:0] dut_rf();
    return {dut.CU1.regfile[3], dut.CU1.regfile[2],
            dut.CU1.regfile[1], dut.CU1.regfile[0]};
  endfunction

  function automatic logic [31:0] mdl_rf();
    return {m_rf[3], m_rf[2], m_rf[1], m_rf[0]};
  endfunction

  // Present ins at FETCH, scramble it afterwards, return after the WB edge.
  task automatic run_instr(input logic [19:0] ins);
    instruction = ins;
    @(posedge clk);
    #1 instruction = 20'($urandom);
    @(posedge clk);
    @(posedge clk);
    #1;
    model_exec(ins);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    instruction = 20'h0;
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (dut.CU1.state_q !== S_FETCH) begin
      n_fail++;
      $display("FAIL reset_state got %0d want %0d",
               dut.CU1.state_q, S_FETCH);
    end
    n_tests++;
    if ({dut.CU1.ir_q, dut.CU1.alu_q, dut.CU1.data_q} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_latches got %h/%h/%h want 0",
               dut.CU1.ir_q, dut.CU1.alu_q, dut.CU1.data_q);
    end
    n_tests++;
    if (dut_rf() !== 32'h03020100) begin
      n_fail++;
      $display("FAIL reset_rf got %h want 03020100", dut_rf());
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_nop();
    int bad;
    run_instr(20'h0F0F0);
    n_tests++;
    if (dut_rf() !== mdl_rf()) begin
      n_fail++;
      $display("FAIL nop_rf got %h want %h", dut_rf(), mdl_rf());
    end
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (dut.data_mem[i] !== 8'h00) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL nop_mem got %0d nonzero words want 0", bad);
    end
  endtask

  task automatic test_program();
    logic [19:0] prog [7];
    logic [7:0]  want [7];
    prog = '{20'h47000, 20'h53000, 20'h72001, 20'hD80F0,
             20'hCC160, 20'hB80F0, 20'h61001};
    want = '{8'd4, 8'd7, 8'd2, 8'd7, 8'd4, 8'd7, 8'hFD};
    for (int k = 0; k < 7; k++) begin
      logic [7:0] got;
      run_instr(prog[k]);
      case (k)
        0: got = dut.CU1.regfile[0];
        1: got = dut.CU1.regfile[1];
        2: got = dut.CU1.regfile[3];
        3: got = dut.data_mem[17];
        4: got = dut.data_mem[24];
        5: got = dut.CU1.regfile[3];
        default: got = dut.CU1.regfile[2];
      endcase
      n_tests++;
      if (got !== want[k]) begin
        n_fail++;
        $display("FAIL prog_%0d ins %h got %h want %h",
                 k, prog[k], got, want[k]);
      end
      if (k == 5) begin
        n_tests++;
        if (dut_rf() !== 32'h07020704) begin
          n_fail++;
          $display("FAIL prog_final_rf got %h want 07020704",
                   dut_rf());
        end
      end
    end
  endtask

  task automatic test_addr_wrap();
    // r2 = 0xFD, off 5 -> 0x102 -> word 2
    run_instr(20'hC8050);
    n_tests++;
    if (dut.data_mem[2] !== 8'd4) begin
      n_fail++;
      $display("FAIL wrap_store got %h want 04", dut.data_mem[2]);
    end
    run_instr(20'hA8050);
    n_tests++;
    if (dut.CU1.regfile[2] !== 8'd4) begin
      n_fail++;
      $display("FAIL wrap_load got %h want 04", dut.CU1.regfile[2]);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    apply_reset();
    run_instr(20'hC4000);
    instruction = 20'hD80F0;
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (dut.CU1.state_q !== S_FETCH || dut.CU1.ir_q !== 20'h0) begin
      n_fail++;
      $display("FAIL midrst_async got st %0d ir %h want 0/0",
               dut.CU1.state_q, dut.CU1.ir_q);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (dut.data_mem[i] !== 8'h00) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midrst_mem got %0d nonzero words want 0", bad);
    end
    n_tests++;
    if (dut_rf() !== 32'h03020100) begin
      n_fail++;
      $display("FAIL midrst_rf got %h want 03020100", dut_rf());
    end
    @(negedge clk);
    rst = 1'b1;
    run_instr(20'h00000);
    n_tests++;
    if (dut_rf() !== mdl_rf() || dut.data_mem[17] !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_after got %h/%h want %h/00",
               dut_rf(), dut.data_mem[17], mdl_rf());
    end
  endtask

  task automatic test_random();
    int rf_bad, mem_bad;
    rf_bad = 0;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      logic [19:0] ins;
      ins = 20'($urandom);
      run_instr(ins);
      n_tests++;
      if (dut_rf() !== mdl_rf()) begin
        n_fail++;
        rf_bad++;
        if (rf_bad <= 5)
          $display("FAIL rand_rf_%0d ins %h got %h want %h",
                   n, ins, dut_rf(), mdl_rf());
      end
    end
    mem_bad = 0;
    for (int i = 0; i < 32; i++) begin
      n_tests++;
      if (dut.data_mem[i] !== m_mem[i]) begin
        n_fail++;
        mem_bad++;
        if (mem_bad <= 5)
          $display("FAIL rand_mem_%0d got %h want %h",
                   i, dut.data_mem[i], m_mem[i]);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    instruction = 20'h0;
    model_reset();
    test_reset();
    test_nop();
    test_program();
    test_addr_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
